// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, one quotient bit per clock.
// Signed requests divide magnitudes and fix the signs up in DONE.
//
// Handshake (start/busy/valid): start is taken only in IDLE. busy is high
// in every CALC cycle. valid pulses for exactly one cycle in DONE, the same
// cycle in which quotient/remainder/div_zero show the new result. cancel
// (or rst) in that cycle suppresses the pulse and keeps the old result.
// Outputs otherwise hold the last delivered result.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dmag_q;     // |divisor|
  logic             qneg_q;     // negate quotient at the end
  logic             rneg_q;     // negate remainder at the end
  logic             zero_q;     // divisor was zero
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dz_out_q;

  logic             a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes; the most-negative value maps onto itself, read as unsigned.
  always_comb begin
    a_neg  = signed_op & dividend[WIDTH-1];
    b_neg  = signed_op & divisor[WIDTH-1];
    a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag  = b_neg ? (~divisor + 1'b1) : divisor;
    accept = start & ~cancel;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {acc_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dmag_q};
    ge      = ~diff[WIDTH];
    q_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = rneg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (divisor == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (cancel)                 state_d = S_IDLE;
        else if (cnt_q == CW'(1))   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: the fixed-up result is visible only in the valid cycle.
  always_comb begin
    busy        = (state_q == S_CALC);
    valid       = (state_q == S_DONE) & ~cancel & ~rst;
    quotient    = valid ? q_fix : quo_out_q;
    remainder   = valid ? r_fix : rem_out_q;
    div_zero    = valid ? zero_q : dz_out_q;
    dbg_state_o = state_q;
  end

  // Datapath: operand capture, iteration, and result hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dmag_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q  <= CW'(WIDTH);
            dmag_q <= b_mag;
            if (divisor == '0) begin
              // Preload the divide-by-zero answer; no sign fix-up applies.
              zero_q <= 1'b1;
              quo_q  <= '1;
              acc_q  <= dividend;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
            end else begin
              zero_q <= 1'b0;
              quo_q  <= a_mag;
              acc_q  <= '0;
              qneg_q <= a_neg ^ b_neg;
              rneg_q <= a_neg;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ge};
        end
        S_DONE: begin
          if (!cancel) begin
            quo_out_q <= q_fix;
            rem_out_q <= r_fix;
            dz_out_q  <= zero_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed-vector and random bench for iter_divider (WIDTH=32).
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, cancel;
  logic [31:0] dividend, divisor;
  logic        busy, valid, div_zero;
  logic [31:0] quotient, remainder;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .valid(valid), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model built on the language operators plus the special cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Called just after a rising edge; start is sampled at the next edge (edge 0).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Samples cycles first..; returns the cycle index where valid appeared (0 = never).
  task automatic wait_valid(input int first, output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    for (int i = first; i <= first + 45; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (valid) begin cyc = i; break; end
    end
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int lat, input string name);
    int cyc, busy_n;
    launch(a, b, s);
    wait_valid(1, cyc, busy_n);
    check({name, " latency"}, cyc, lat);
    check({name, " busy_cycles"}, busy_n, lat - 1);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk);
    check({name, " valid_one_cycle"}, {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, busy_n, nv;
    logic [31:0] ra, rb, eq, er;
    logic        rs, edz;

    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 33, "u100_7"};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33, "s-100_7"};
    vecs[2] = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2,         1'b0, 33, "s100_-7"};
    vecs[3] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE,  1'b0, 33, "s-100_-7"};
    vecs[4] = '{32'h12345678,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h12345678,  1'b1, 1,  "s_div0"};
    vecs[5] = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  1'b1, 1,  "u_div0"};
    vecs[6] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, 33, "s_ovf"};
    vecs[7] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0, 33, "u_min_max"};
    vecs[8] = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0, 33, "u_max_1"};
    vecs[9] = '{32'd7,         32'd100,       1'b0, 32'd0,         32'd7,         1'b0, 33, "u7_100"};

    // Reset
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy",      {31'd0, busy}, 32'd0);
    check("reset valid",     {31'd0, valid}, 32'd0);
    check("reset quotient",  quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_zero",  {31'd0, div_zero}, 32'd0);
    check("reset state",     {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[k])
      run_vec(vecs[k].a, vecs[k].b, vecs[k].s, vecs[k].q, vecs[k].r, vecs[k].dz,
              vecs[k].lat, vecs[k].name);

    // start while busy is ignored
    launch(32'd100, 32'd7, 1'b0);                 // now in cycle 1
    for (int i = 1; i < 10; i++) @(posedge clk);  // now in cycle 10
    #1;
    dividend = 32'd999; divisor = 32'd3; signed_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;                                 // now in cycle 11
    wait_valid(11, cyc, busy_n);
    check("ignore_start latency",   cyc, 33);
    check("ignore_start quotient",  quotient, 32'd14);
    check("ignore_start remainder", remainder, 32'd2);
    @(posedge clk); #1;

    // cancel in CALC at cycle 20
    launch(32'd1000, 32'd3, 1'b0);
    nv = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk); if (valid) nv++;
      @(posedge clk);
    end
    #1 cancel = 1'b1;                             // cycle 20
    @(negedge clk); if (valid) nv++;
    @(posedge clk); #1;
    cancel = 1'b0;                                // cycle 21
    @(negedge clk);
    if (valid) nv++;
    check("cancel busy_c21",   {31'd0, busy}, 32'd0);
    check("cancel no_valid",   nv, 0);
    check("cancel quotient",   quotient, 32'd14);
    check("cancel remainder",  remainder, 32'd2);
    @(posedge clk); #1;                           // cycle 22
    run_vec(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 33, "after_cancel");

    // cancel together with start in IDLE drops the request
    dividend = 32'd77; divisor = 32'd5; signed_op = 1'b0;
    start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    nv = 0; busy_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid) nv++;
      if (busy) busy_n++;
    end
    check("idle_cancel busy",     busy_n, 0);
    check("idle_cancel no_valid", nv, 0);
    check("idle_cancel quotient", quotient, 32'd8);
    @(posedge clk); #1;

    // reset at cycle 15 of an operation
    launch(32'd1000, 32'd3, 1'b0);
    for (int i = 1; i < 15; i++) @(posedge clk);
    #1 rst = 1'b1;                                // cycle 15
    @(posedge clk); #1;
    rst = 1'b0;                                   // cycle 16
    @(negedge clk);
    check("midreset busy",      {31'd0, busy}, 32'd0);
    check("midreset valid",     {31'd0, valid}, 32'd0);
    check("midreset quotient",  quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset div_zero",  {31'd0, div_zero}, 32'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); if (valid) nv++;
    end
    check("midreset no_valid", nv, 0);
    @(posedge clk); #1;

    // Random signed/unsigned pairs against the model
    for (int n = 0; n < 1000; n++) begin
      ra = (n % 17 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'd0 - $urandom_range(1, 300);
        4:       rb = $urandom_range(1, 65535);
        default: rb = $urandom;
      endcase
      rs = $urandom_range(0, 1);
      model(ra, rb, rs, eq, er, edz);
      run_vec(ra, rb, rs, eq, er, edz, (rb == 32'd0) ? 1 : 33, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
